glyph_row_serializer: RTL and testbench

GLYPH_ROW_SERIALIZER -- requirements
Module: glyph_row_serializer

---
 rtl/glyph_row_serializer.sv | 90 +++++++++
 tb/tb_glyph_row_serializer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_row_serializer.sv
// Fetches one glyph row from a registered-output ROM and streams it out
// MSB first, one pixel per accepted transfer.
//
// state | meaning
// IDLE  | waiting for a row request, req_ready high
// FETCH | rom_addr presented, ROM registering the word
// LOAD  | rom_q holds the row word, capture into shift register
// SHIFT | emitting pixels, advance on pix_ready
module glyph_row_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 8,
  parameter int ROW_BITS   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_WIDTH-ROW_BITS-1:0] req_glyph,
  input  logic [ROW_BITS-1:0]            req_row,
  output logic [ADDR_WIDTH-1:0]          rom_addr,
  input  logic [DATA_WIDTH-1:0]          rom_q,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic                           pix_bit,
  output logic                           pix_last,
  output logic                           busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;
  logic                  accept;
  logic                  xfer;

  assign accept = req_valid && req_ready;
  assign xfer   = pix_valid && pix_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (xfer && pix_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    pix_valid = (state == SHIFT);
    pix_bit   = (state == SHIFT) ? shreg[DATA_WIDTH-1] : 1'b0;
    pix_last  = (state == SHIFT) && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
    end else if (accept) begin
      rom_addr <= {req_glyph, req_row};
    end
  end

  // counter clears on the final pixel so it never runs past DATA_WIDTH-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == LOAD) begin
      shreg <= rom_q;
      cnt   <= '0;
    end else if (xfer) begin
      shreg <= shreg << 1;
      cnt   <= pix_last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_glyph_row_serializer.sv
// Bench for glyph_row_serializer: queue-based row model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_glyph_row_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_glyph = '0;
  logic [3:0]  req_row = '0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_q = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_bit;
  logic        pix_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [23:0] rom [256];
  bit          garbage = 1'b0;
  bit          load_flag = 1'b0;

  // model: a row is 2 cycles of latency followed by a queue of pixels
  bit          busy_m = 1'b0;
  int          wait_m = 0;
  bit          q[$];
  logic [7:0]  exp_addr = '0;
  bit          exp_valid;

  // collector of transferred pixels
  bit          col_q[$];
  int          last_cnt = 0;
  int          last_idx = -1;

  bit          tog_en = 1'b0;
  logic [3:0]  pat = 4'b1001;
  int          ph = 0;

  glyph_row_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_glyph (req_glyph),
    .req_row   (req_row),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_bit   (pix_bit),
    .pix_last  (pix_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // registered ROM; in garbage mode only the LOAD-cycle word is real
  always @(posedge clk)
    rom_q <= (garbage && !load_flag) ? 24'($urandom) : rom[rom_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m = 1'b0;
      wait_m = 0;
      q.delete();
      exp_addr = '0;
    end else if (!busy_m) begin
      if (req_valid) begin
        exp_addr = {req_glyph, req_row};
        for (int i = 23; i >= 0; i--) q.push_back(rom[exp_addr][i]);
        busy_m = 1'b1;
        wait_m = 2;
      end
    end else if (wait_m > 0) begin
      wait_m = wait_m - 1;
    end else if (pix_ready) begin
      void'(q.pop_front());
      if (q.size() == 0) busy_m = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit eb;
    bit el;
    exp_valid = busy_m && (wait_m == 0) && (q.size() > 0);
    eb = exp_valid ? q[0] : 1'b0;
    el = exp_valid && (q.size() == 1);
    checks++;
    if (req_ready !== !busy_m || busy !== busy_m || pix_valid !== exp_valid ||
        pix_last !== el || rom_addr !== exp_addr || (exp_valid && pix_bit !== eb)) begin
      errors++;
      $display("FAIL cycle_compare t=%0t actual rdy=%b busy=%b v=%b bit=%b last=%b addr=%h required rdy=%b busy=%b v=%b bit=%b last=%b addr=%h",
               $time, req_ready, busy, pix_valid, pix_bit, pix_last, rom_addr,
               !busy_m, busy_m, exp_valid, eb, el, exp_addr);
    end
    load_flag = busy_m && (wait_m == 2);
    if (rst_n && pix_valid && pix_ready) begin
      if (pix_last) begin
        last_cnt++;
        last_idx = col_q.size();
      end
      col_q.push_back(pix_bit);
    end
  end

  always @(posedge clk) begin
    #1;
    if (tog_en) begin
      pix_ready = pat[ph];
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_col();
    col_q.delete();
    last_cnt = 0;
    last_idx = -1;
  endtask

  function automatic logic [23:0] col_word(input int off);
    logic [23:0] w = '0;
    for (int i = 0; i < 24; i++)
      w = {w[22:0], (off + i < col_q.size()) ? col_q[off + i] : 1'b0};
    return w;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!req_ready && n < 300) begin
      step();
      n++;
    end
    check({name, "_idle_timeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic request(input logic [3:0] g, input logic [3:0] r);
    req_glyph = g;
    req_row   = r;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) rom[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A};
    rom[8'h3A] = 24'hA50FC3;
    rom[8'hFF] = 24'h800001;
    rom[8'h12] = 24'h5C3E91;

    #2 rst_n = 1'b0;
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_bit", 32'(pix_bit), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    rst_n = 1'b1;
    step();

    // basic row, pix_ready held high
    clear_col();
    pix_ready = 1'b1;
    request(4'h3, 4'hA);
    check("accept_rom_addr", 32'(rom_addr), 32'h3A);
    n = 1;
    while (!pix_valid && n < 10) begin
      step();
      n++;
    end
    check("first_valid_cycle", 32'(n), 32'd3);
    wait_idle("row1");
    check("row1_count", 32'(col_q.size()), 32'd24);
    check("row1_bits", 32'(col_word(0)), 32'hA50FC3);
    check("row1_last_cnt", 32'(last_cnt), 32'd1);
    check("row1_last_idx", 32'(last_idx), 32'd23);

    // stalls from a 1,0,0,1 ready pattern
    step();
    clear_col();
    ph = 0;
    tog_en = 1'b1;
    request(4'h3, 4'hA);
    wait_idle("row2");
    tog_en = 1'b0;
    pix_ready = 1'b1;
    check("row2_count", 32'(col_q.size()), 32'd24);
    check("row2_bits", 32'(col_word(0)), 32'hA50FC3);
    check("row2_last_idx", 32'(last_idx), 32'd23);

    // request held during an active row is taken only once idle
    step();
    clear_col();
    request(4'h3, 4'hA);
    req_glyph = 4'hF;
    req_row   = 4'hF;
    req_valid = 1'b1;
    n = 0;
    while (rom_addr != 8'hFF && n < 100) begin
      step();
      n++;
    end
    req_valid = 1'b0;
    check("held_req_addr", 32'(rom_addr), 32'hFF);
    step();
    wait_idle("row3");
    check("row3_count", 32'(col_q.size()), 32'd48);
    check("row3_bits_a", 32'(col_word(0)), 32'hA50FC3);
    check("row3_bits_b", 32'(col_word(24)), 32'h800001);
    check("row3_last_cnt", 32'(last_cnt), 32'd2);

    // reset partway through a row
    step();
    clear_col();
    request(4'h3, 4'hA);
    n = 0;
    while (col_q.size() < 10 && n < 50) begin
      step();
      n++;
    end
    check("pre_reset_pixels", 32'(col_q.size()), 32'd10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
    check("mid_rst_pix_last", 32'(pix_last), 32'd0);
    check("mid_rst_rom_addr", 32'(rom_addr), 32'h0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    clear_col();
    request(4'hF, 4'hF);
    wait_idle("row4");
    check("row4_count", 32'(col_q.size()), 32'd24);
    check("row4_bits", 32'(col_word(0)), 32'h800001);

    // rom_q noise outside the LOAD cycle
    garbage = 1'b1;
    step();
    step();
    clear_col();
    request(4'h1, 4'h2);
    wait_idle("row5");
    step();
    step();
    garbage = 1'b0;
    check("row5_count", 32'(col_q.size()), 32'd24);
    check("row5_bits", 32'(col_word(0)), 32'h5C3E91);
    check("row5_rom_addr", 32'(rom_addr), 32'h12);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
